// File: rtl/mandel_engine.sv
// mandel_engine: one-point Mandelbrot/Julia escape-time engine.
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready with in_x, in_y,
//   julia_mode, julia_cx, julia_cy, max_iter (sampled at accept); abort;
//   out_valid/out_ready with out_iter, out_escaped; busy (state != IDLE).
// Optional: `define MANDEL_PERIOD_CHECK_EN adds checkpoint-based early exit.

module mandel_iter #(
    parameter int BITS = 16
) (
    input  logic                   clk,
    input  logic                   phase,
    input  logic signed [BITS-1:0] cx,
    input  logic signed [BITS-1:0] cy,
    input  logic signed [BITS-1:0] x,
    input  logic signed [BITS-1:0] y,
    output logic signed [BITS-1:0] x_out,
    output logic signed [BITS-1:0] y_out,
    output logic                   escape
);
    localparam int F = BITS - 3;
    localparam int W = BITS + 4;
    // 4.0 in Q.F is 2^(BITS-1)
    localparam logic signed [W-1:0] FOUR = W'(1) << (BITS - 1);

    logic signed [2*BITS-1:0] pxx, pyy, pxy;
    logic signed [W-1:0] xx_q, yy_q, xy2_q;
    logic signed [W-1:0] mag, xn, yn, cxw, cyw;
    logic ovf_x, ovf_y;

    assign pxx = x * x;
    assign pyy = y * y;
    assign pxy = x * y;

    // Phase 0: register the truncated products (xy2 already holds 2xy).
    always_ff @(posedge clk) begin
        if (!phase) begin
            xx_q  <= W'(pxx >>> F);
            yy_q  <= W'(pyy >>> F);
            xy2_q <= W'(pxy >>> (F - 1));
        end
    end

    assign cxw = {{(W-BITS){cx[BITS-1]}}, cx};
    assign cyw = {{(W-BITS){cy[BITS-1]}}, cy};

    // Phase 1: combine into the next z and the escape decision.
    assign mag = xx_q + yy_q;
    assign xn  = xx_q - yy_q + cxw;
    assign yn  = xy2_q + cyw;

    // Result must fit in BITS signed bits, otherwise the point escapes.
    assign ovf_x = xn[W-1:BITS-1] != {(W-BITS+1){xn[BITS-1]}};
    assign ovf_y = yn[W-1:BITS-1] != {(W-BITS+1){yn[BITS-1]}};

    assign escape = (mag >= FOUR) || ovf_x || ovf_y;
    assign x_out  = xn[BITS-1:0];
    assign y_out  = yn[BITS-1:0];
endmodule

module mandel_engine #(
    parameter int BITS      = 16,
    parameter int ITER_BITS = 7
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [BITS-1:0] in_x,
    input  logic signed [BITS-1:0] in_y,
    input  logic                   julia_mode,
    input  logic signed [BITS-1:0] julia_cx,
    input  logic signed [BITS-1:0] julia_cy,
    input  logic [ITER_BITS-1:0]   max_iter,
    input  logic                   abort,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ITER_BITS-1:0]   out_iter,
    output logic                   out_escaped,
    output logic                   busy
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0] state_q, state_d;
    logic phase_q, phase_d;
    logic [ITER_BITS-1:0] iter_q, iter_d, lim_q, lim_d;
    logic [ITER_BITS-1:0] oit_q, oit_d, iter_inc;
    logic oesc_q, oesc_d, ov_q, ov_d;
    logic signed [BITS-1:0] cx_q, cx_d, cy_q, cy_d;
    logic signed [BITS-1:0] zx_q, zx_d, zy_q, zy_d;
    logic signed [BITS-1:0] xo, yo;
    logic esc;
`ifdef MANDEL_PERIOD_CHECK_EN
    logic signed [BITS-1:0] sx_q, sx_d, sy_q, sy_d;
    logic pow2;
`endif

    mandel_iter #(.BITS(BITS)) u_iter (
        .clk   (clk),
        .phase (phase_q),
        .cx    (cx_q),
        .cy    (cy_q),
        .x     (zx_q),
        .y     (zy_q),
        .x_out (xo),
        .y_out (yo),
        .escape(esc)
    );

    assign iter_inc = iter_q + ITER_BITS'(1);
`ifdef MANDEL_PERIOD_CHECK_EN
    assign pow2 = (iter_inc & (iter_inc - ITER_BITS'(1))) == '0;
`endif

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        iter_d  = iter_q;
        lim_d   = lim_q;
        oit_d   = oit_q;
        oesc_d  = oesc_q;
        ov_d    = ov_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        zx_d    = zx_q;
        zy_d    = zy_q;
`ifdef MANDEL_PERIOD_CHECK_EN
        sx_d    = sx_q;
        sy_d    = sy_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    cx_d    = julia_mode ? julia_cx : in_x;
                    cy_d    = julia_mode ? julia_cy : in_y;
                    zx_d    = in_x;
                    zy_d    = in_y;
                    lim_d   = max_iter;
                    iter_d  = '0;
                    phase_d = 1'b0;
                    state_d = S_RUN;
`ifdef MANDEL_PERIOD_CHECK_EN
                    sx_d    = in_x;
                    sy_d    = in_y;
`endif
                end
            end
            S_RUN: begin
                phase_d = ~phase_q;
                if (phase_q) begin
                    if (esc) begin
                        state_d = S_DONE;
                        oesc_d  = 1'b1;
                        oit_d   = iter_q;
                    end else if (iter_q == lim_q) begin
                        state_d = S_DONE;
                        oesc_d  = 1'b0;
                        oit_d   = lim_q;
`ifdef MANDEL_PERIOD_CHECK_EN
                    end else if (xo == sx_q && yo == sy_q) begin
                        // Orbit revisited the checkpoint: it never escapes.
                        state_d = S_DONE;
                        oesc_d  = 1'b0;
                        oit_d   = lim_q;
`endif
                    end else begin
                        zx_d   = xo;
                        zy_d   = yo;
                        iter_d = iter_inc;
`ifdef MANDEL_PERIOD_CHECK_EN
                        if (pow2) begin
                            sx_d = xo;
                            sy_d = yo;
                        end
`endif
                    end
                end
            end
            S_DONE: begin
                // out_valid rises one clock after entering DONE.
                ov_d = 1'b1;
                if (ov_q && out_ready) begin
                    ov_d    = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d = S_IDLE;
            ov_d    = 1'b0;
            phase_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            phase_q <= 1'b0;
            iter_q  <= '0;
            lim_q   <= '0;
            oit_q   <= '0;
            oesc_q  <= 1'b0;
            ov_q    <= 1'b0;
            cx_q    <= '0;
            cy_q    <= '0;
            zx_q    <= '0;
            zy_q    <= '0;
`ifdef MANDEL_PERIOD_CHECK_EN
            sx_q    <= '0;
            sy_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            iter_q  <= iter_d;
            lim_q   <= lim_d;
            oit_q   <= oit_d;
            oesc_q  <= oesc_d;
            ov_q    <= ov_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            zx_q    <= zx_d;
            zy_q    <= zy_d;
`ifdef MANDEL_PERIOD_CHECK_EN
            sx_q    <= sx_d;
            sy_q    <= sy_d;
`endif
        end
    end

    assign in_ready    = (state_q == S_IDLE) && rst_n;
    assign out_valid   = ov_q;
    assign out_iter    = oit_q;
    assign out_escaped = oesc_q;
    assign busy        = state_q != S_IDLE;
endmodule

// File: tb/tb_mandel_engine.sv
// tb_mandel_engine: directed + random checks of mandel_engine
// against an integer escape-time model.

module tb_mandel_engine;
    localparam int BITS = 16;
    localparam int IB   = 7;
    localparam int F    = BITS - 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic in_ready;
    logic signed [BITS-1:0] in_x = '0, in_y = '0;
    logic julia_mode = 1'b0;
    logic signed [BITS-1:0] julia_cx = '0, julia_cy = '0;
    logic [IB-1:0] max_iter = '0;
    logic abort = 1'b0;
    logic out_valid;
    logic out_ready = 1'b0;
    logic [IB-1:0] out_iter;
    logic out_escaped;
    logic busy;

    int checks = 0;
    int failures = 0;

    mandel_engine #(.BITS(BITS), .ITER_BITS(IB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_x       (in_x),
        .in_y       (in_y),
        .julia_mode (julia_mode),
        .julia_cx   (julia_cx),
        .julia_cy   (julia_cy),
        .max_iter   (max_iter),
        .abort      (abort),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_iter   (out_iter),
        .out_escaped(out_escaped),
        .busy       (busy)
    );

    task automatic chk(input string tag, input longint got,
                       input longint exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Escape-time reference: iterate z = z^2 + c on integers scaled
    // by 2^F, truncating products toward -inf.
    function automatic void model(
        input longint cx, input longint cy,
        input longint zx0, input longint zy0, input int lim,
        output int it, output int esc, output int lat);
        longint zx, zy, sx, sy, xx, yy, xy2, mag, xn, yn;
        int checks_made;
        bit e;
        zx = zx0; zy = zy0; sx = zx0; sy = zy0;
        it = 0; esc = 0; checks_made = 0;
        while (1) begin
            checks_made++;
            xx  = (zx * zx) >>> F;
            yy  = (zy * zy) >>> F;
            xy2 = (zx * zy) >>> (F - 1);
            mag = xx + yy;
            xn  = xx - yy + cx;
            yn  = xy2 + cy;
            e = (mag >= (64'sd4 <<< F)) ||
                xn < -32768 || xn > 32767 ||
                yn < -32768 || yn > 32767;
            if (e) begin esc = 1; break; end
            if (it == lim) begin esc = 0; break; end
`ifdef MANDEL_PERIOD_CHECK_EN
            if (xn == sx && yn == sy) begin
                it = lim; esc = 0; break;
            end
`endif
            zx = xn; zy = yn; it++;
`ifdef MANDEL_PERIOD_CHECK_EN
            if ((it & (it - 1)) == 0) begin sx = zx; sy = zy; end
`endif
        end
        lat = 2 * checks_made + 1;
    endfunction

    task automatic start_job(input bit m,
        input logic signed [BITS-1:0] x, input logic signed [BITS-1:0] y,
        input logic signed [BITS-1:0] cx, input logic signed [BITS-1:0] cy,
        input int lim);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        in_valid = 1'b1; julia_mode = m;
        in_x = x; in_y = y; julia_cx = cx; julia_cy = cy;
        max_iter = IB'(lim);
        chk("in_ready_accept", in_ready, 1);
        @(posedge clk);
        #1;
        // Scramble inputs after accept; they must not matter.
        in_valid = 1'b0;
        in_x = BITS'($urandom); in_y = BITS'($urandom);
        julia_cx = BITS'($urandom); julia_cy = BITS'($urandom);
        julia_mode = 1'($urandom); max_iter = IB'($urandom);
    endtask

    task automatic finish_job(input int eit, input int eesc,
                              input int elat, input int hold);
        int lat, stable;
        logic [IB-1:0] it0;
        logic e0;
        lat = 0;
        while (!out_valid && lat < 400) begin
            @(posedge clk); #1; lat++;
        end
        chk("latency", lat, elat);
        chk("out_iter", out_iter, eit);
        chk("out_escaped", out_escaped, eesc);
        chk("busy_done", busy, 1);
        chk("in_ready_done", in_ready, 0);
        it0 = out_iter; e0 = out_escaped; stable = 1;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_iter !== it0 ||
                out_escaped !== e0 || in_ready !== 1'b0)
                stable = 0;
        end
        if (hold > 0) chk("hold_stable", stable, 1);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("out_valid_clr", out_valid, 0);
        chk("in_ready_idle", in_ready, 1);
    endtask

    task automatic job(input bit m,
        input logic signed [BITS-1:0] x, input logic signed [BITS-1:0] y,
        input logic signed [BITS-1:0] cx, input logic signed [BITS-1:0] cy,
        input int lim, input int hold);
        int it, esc, lat;
        longint mcx, mcy;
        mcx = m ? longint'(cx) : longint'(x);
        mcy = m ? longint'(cy) : longint'(y);
        model(mcx, mcy, longint'(x), longint'(y), lim, it, esc, lat);
        start_job(m, x, y, cx, cy, lim);
        finish_job(it, esc, lat, hold);
    endtask

    initial begin
        int n, t, lp;
        logic signed [BITS-1:0] rx, ry, rcx, rcy;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_iter", out_iter, 0);
        chk("rst_out_esc", out_escaped, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("in_ready_post_rst", in_ready, 1);

        // Directed points with hand-derived results.
        start_job(0, 16'sh3000, 0, 0, 0, 127);
        finish_job(1, 1, 5, 0);
        start_job(0, 16'sh6000, 0, 0, 0, 127);
        finish_job(0, 1, 3, 20);
`ifdef MANDEL_PERIOD_CHECK_EN
        start_job(0, 0, 0, 0, 0, 127);
        finish_job(127, 0, 3, 1);
        start_job(0, 16'shE000, 0, 0, 0, 127);
        finish_job(127, 0, 9, 0);
        start_job(1, 0, 0, 16'shE000, 0, 20);
        finish_job(20, 0, 9, 0);
`else
        start_job(0, 0, 0, 0, 0, 127);
        finish_job(127, 0, 257, 1);
        start_job(0, 16'shE000, 0, 0, 0, 127);
        finish_job(127, 0, 257, 0);
        start_job(1, 0, 0, 16'shE000, 0, 20);
        finish_job(20, 0, 43, 0);
`endif
        start_job(0, 0, 0, 0, 0, 0);
        finish_job(0, 0, 3, 0);
        start_job(1, 16'sh2000, 16'sh2000, 0, 0, 127);
        finish_job(1, 1, 5, 2);

        // Reset mid-RUN.
        start_job(0, 0, 0, 0, 0, 127);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("in_ready_in_rst", in_ready, 0);
        @(posedge clk);
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_out_valid", out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_busy2", busy, 0);

        // Abort in RUN: no result, then a normal job.
        start_job(0, 0, 0, 0, 0, 127);
        repeat (14) @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        n = 0;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk); #1;
            if (out_valid) n++;
        end
        chk("abort_no_result", n, 0);
        job(0, 16'sh3000, 0, 0, 0, 127, 0);

        // Abort in DONE beats the result handshake.
        start_job(0, 16'sh6000, 0, 0, 0, 127);
        n = 0;
        while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
        chk("abort_done_valid", out_valid, 1);
        @(negedge clk);
        abort = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0; out_ready = 1'b0;
        chk("abort_done_ov", out_valid, 0);
        chk("abort_done_busy", busy, 0);
        chk("abort_done_rdy", in_ready, 1);

        // Random points around the set against the model.
        for (int j = 0; j < 40; j++) begin
            t  = int'($urandom_range(0, 32768)) - 20480;
            rx = BITS'(t);
            t  = int'($urandom_range(0, 24000)) - 12000;
            ry = BITS'(t);
            t  = int'($urandom_range(0, 16000)) - 8000;
            rcx = BITS'(t);
            t  = int'($urandom_range(0, 16000)) - 8000;
            rcy = BITS'(t);
            lp = int'($urandom_range(0, 127));
            job(1'($urandom), rx, ry, rcx, rcy, lp,
                int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mandel_engine.md
Name: mandel_engine

Overview:
- Parametrised successor to the single-pixel Mandelbrot iterator top.
- Accepts one point per valid/ready handshake and iterates z' = z^2 + c using the existing two-phase mandel_iter datapath (one iteration per 2 clocks).
- Returns the escape iteration count through a valid/ready result port.
- Adds a runtime iteration limit, Julia mode, abort, and generic width; sits between the pixel scheduler and the colour/output stage.

Parameters:
- BITS, 16, fixed-point word width, signed Q3.(BITS-3) (3 integer bits incl. sign, BITS-3 fraction bits); passed to mandel_iter.
- ITER_BITS, 7, width of the iteration counter and limit.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- in_valid  in  1  point request valid
- in_ready  out  1  engine can accept a point
- in_x  in  BITS  point real part, Q3.(BITS-3)
- in_y  in  BITS  point imaginary part
- julia_mode  in  1  0 = Mandelbrot, 1 = Julia; sampled at accept
- julia_cx  in  BITS  Julia constant real part; sampled at accept
- julia_cy  in  BITS  Julia constant imaginary part; sampled at accept
- max_iter  in  ITER_BITS  iteration limit; sampled at accept
- abort  in  1  discard the current job
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_iter  out  ITER_BITS  iteration count at termination
- out_escaped  out  1  1 = point escaped, 0 = limit (or period) reached
- busy  out  1  state != IDLE

Behaviour:
- States: IDLE, RUN, DONE.
- in_ready = (state == IDLE) && rst_n. Accept = in_valid && in_ready on a rising edge.
- Accept, Mandelbrot: c <= (in_x, in_y); z <= (in_x, in_y).
- Accept, Julia: c <= (julia_cx, julia_cy); z <= (in_x, in_y).
- Accept, both modes: lim <= max_iter; iter <= 0; phase <= 0; state <= RUN.
- RUN: phase toggles every clock. mandel_iter is driven with (c, z, phase).
- On each phase=1 cycle, checked in this priority order:
  - escape high → DONE, out_escaped <= 1, out_iter <= iter.
  - else iter == lim → DONE, out_escaped <= 0, out_iter <= lim.
  - else z <= (x_out, y_out), iter <= iter + 1.
- Latency from the accept edge to out_valid high = 2·out_iter + 3 clocks.
- max_iter = 0: a single check is made; result is iter 0, escaped = escape flag of z0.
- DONE: out_valid = 1. out_iter and out_escaped are held stable until out_valid && out_ready, then state <= IDLE. in_ready is 1 on the following cycle; there is no back-to-back overlap.
- abort (any state, rst_n high): state <= IDLE next edge, out_valid <= 0, no result is emitted. abort has priority over accept and result handshake in the same cycle.
- in_valid is ignored in RUN and DONE. Input changes after accept have no effect.
- Reset (rst_n low at an edge, any state incl. mid-RUN): state = IDLE, out_valid = 0, out_iter = 0, out_escaped = 0, busy = 0, iter = 0, phase = 0. in_ready = 0 while rst_n is low.
- Arithmetic, overflow and escape criterion (|z|^2 ≥ 4 or overflow) are exactly those of mandel_iter. The engine performs no extra rounding.

Optional Feature:
- Macro: MANDEL_PERIOD_CHECK_EN.
- Enabled, storage: keep a checkpoint register (sx, sy). Load it with z0 at accept, and with the newly committed z whenever the new iter value is a power of two.
- Enabled, early exit: on each phase=1 commit, if (x_out, y_out) == (sx, sy) bit-exactly and escape is low, go to DONE with out_escaped = 0 and out_iter = lim. The limit check still wins when iter == lim.
- Result contents therefore equal the non-feature result for periodic orbits; only latency shortens.
- Disabled: no checkpoint logic, no early exit.

Test Plan:
- Reset mid-RUN: accept c=(0,0), max_iter=127, assert rst_n=0 for 1 clock after 10 clocks → out_valid=0, busy=0, in_ready=1 one clock after rst_n rises.
- Mandelbrot, BITS=16: in=(0x3000,0) i.e. 1.5, max_iter=127 → out_iter=1, out_escaped=1, out_valid exactly 5 clocks after accept. in=(0x6000,0) i.e. 3.0 → iter 0, escaped 1, latency 3.
- Limit, feature off: c=(0,0), max_iter=127 → out_iter=127, escaped=0, latency 257. Same with max_iter=0 → iter 0, escaped 0, latency 3.
- Julia: julia_mode=1, julia_c=(0,0), in=(0x2000,0x2000) i.e. z0=1+1i → iter 1, escaped 1. julia_c=(0xE000,0) i.e. -1.0, in=(0,0), max_iter=20 → iter 20, escaped 0.
- Handshake/abort: hold out_ready=0 for 20 clocks in DONE → outputs stable, in_ready=0. Then pulse out_ready → IDLE. Abort in RUN → no out_valid, next job is accepted normally.
- MANDEL_PERIOD_CHECK_EN defined: c=(0,0), max_iter=127 → iter 127, escaped 0, latency 3. c=(0xE000,0), i.e. -1.0, period 2 → iter 127, escaped 0, latency < 20.
